// File: rtl/feature_template_classifier.sv
// feature_template_classifier
//   Nearest-template classifier for the indexed MFCC feature stream. Each accepted
//   element adds its distance to every stored template, with all classes updated in
//   parallel. At frame end the per-class totals are frozen into a snapshot bank. A
//   sequential argmin scan then reports the nearest class, its distance and a reject flag.
//
// Optional feature:
//   `define FEAT_CLASSIFIER_SQDIST_EN -> squared distance (difference saturated to 16 bits)
//                                        with one extra input pipeline stage.
//   undefined (default)              -> L1 absolute difference.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   x_i, x_index, write signed feature element, its index, valid strobe
//   tmpl_we, tmpl_class, tmpl_index, tmpl_data   template write port
//   threshold           unsigned reject threshold, sampled when the result is registered
//   busy                argmin scan in progress
//   result_dv           one-cycle result strobe
//   result, result_dist winning class and distance (held until the next result_dv)
//   reject              result_dist > threshold
//   frame_err           one-cycle pulse on index sequencing error or overrun
module feature_template_classifier #(
    parameter int unsigned BWIDTH      = 32,
    parameter int unsigned FEAT_DIM    = 12,
    parameter int unsigned NUM_CLASSES = 5,
    parameter int unsigned CWIDTH      = 3,
    parameter int unsigned IWIDTH      = 5,
    parameter int unsigned AWIDTH      = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [BWIDTH-1:0] x_i,
    input  logic        [IWIDTH-1:0] x_index,
    input  logic                     write,
    input  logic                     tmpl_we,
    input  logic        [CWIDTH-1:0] tmpl_class,
    input  logic        [IWIDTH-1:0] tmpl_index,
    input  logic signed [BWIDTH-1:0] tmpl_data,
    input  logic        [AWIDTH-1:0] threshold,
    output logic                     busy,
    output logic                     result_dv,
    output logic        [CWIDTH-1:0] result,
    output logic        [AWIDTH-1:0] result_dist,
    output logic                     reject,
    output logic                     frame_err
);

    localparam int unsigned FIdxW = (FEAT_DIM > 1) ? $clog2(FEAT_DIM) : 1;
    localparam int unsigned CIdxW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
`ifdef FEAT_CLASSIFIER_SQDIST_EN
    localparam int unsigned TermW = 32;
    localparam logic signed [BWIDTH:0] SatHi = (BWIDTH+1)'(32767);
    localparam logic signed [BWIDTH:0] SatLo = (BWIDTH+1)'(-32768);
`else
    localparam int unsigned TermW = BWIDTH + 1;
`endif

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    function automatic logic [TermW-1:0] dist_term(input logic signed [BWIDTH-1:0] a,
                                                   input logic signed [BWIDTH-1:0] b);
        logic signed [BWIDTH:0] d;
`ifdef FEAT_CLASSIFIER_SQDIST_EN
        logic signed [15:0] s;
        logic signed [31:0] p;
        d = {a[BWIDTH-1], a} - {b[BWIDTH-1], b};
        if (d > SatHi)      s = 16'sh7fff;
        else if (d < SatLo) s = 16'sh8000;
        else                s = d[15:0];
        p = 32'(s) * 32'(s);
        return $unsigned(p);
`else
        d = {a[BWIDTH-1], a} - {b[BWIDTH-1], b};
        return d[BWIDTH] ? $unsigned(-d) : $unsigned(d);
`endif
    endfunction

    function automatic logic [AWIDTH-1:0] sat_add(input logic [AWIDTH-1:0] acc,
                                                  input logic [TermW-1:0]  term);
        logic [AWIDTH:0] s;
        s = {1'b0, acc} + (AWIDTH+1)'(term);
        return s[AWIDTH] ? '1 : s[AWIDTH-1:0];
    endfunction

    // Template storage deliberately has no reset.
    logic signed [BWIDTH-1:0] tmpl_q [NUM_CLASSES][FEAT_DIM];

    always_ff @(posedge clk) begin
        if (tmpl_we && (tmpl_class < CWIDTH'(NUM_CLASSES)) && (tmpl_index < IWIDTH'(FEAT_DIM))) begin
            tmpl_q[tmpl_class[CIdxW-1:0]][tmpl_index[FIdxW-1:0]] <= tmpl_data;
        end
    end

    // Per-class distance terms, read from the template before any same-edge template write.
    logic [TermW-1:0] term_c [NUM_CLASSES];
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            term_c[c] = '0;
            if (x_index < IWIDTH'(FEAT_DIM)) begin
                term_c[c] = dist_term(x_i, tmpl_q[c][x_index[FIdxW-1:0]]);
            end
        end
    end

    logic              p_write;
    logic [IWIDTH-1:0] p_index;
    logic [TermW-1:0]  p_term [NUM_CLASSES];
`ifdef FEAT_CLASSIFIER_SQDIST_EN
    logic              p_write_q;
    logic [IWIDTH-1:0] p_index_q;
    logic [TermW-1:0]  p_term_q [NUM_CLASSES];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_write_q <= 1'b0;
            p_index_q <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) p_term_q[c] <= '0;
        end else begin
            p_write_q <= write;
            p_index_q <= x_index;
            for (int c = 0; c < NUM_CLASSES; c++) p_term_q[c] <= term_c[c];
        end
    end
    assign p_write = p_write_q;
    assign p_index = p_index_q;
    always_comb for (int c = 0; c < NUM_CLASSES; c++) p_term[c] = p_term_q[c];
`else
    assign p_write = write;
    assign p_index = x_index;
    always_comb for (int c = 0; c < NUM_CLASSES; c++) p_term[c] = term_c[c];
`endif

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] acc_q [NUM_CLASSES];
    logic [AWIDTH-1:0] acc_d [NUM_CLASSES];
    logic [AWIDTH-1:0] sum   [NUM_CLASSES];
    logic [AWIDTH-1:0] snap_q [NUM_CLASSES];
    logic [IWIDTH-1:0] idx_q, idx_d;
    logic              sync_q, sync_d;
    logic              err_d, err_q;
    logic              snap_load;
    logic              is_zero, accept;

    // Sequencing and accumulation.
    always_comb begin
        acc_d     = acc_q;
        idx_d     = idx_q;
        sync_d    = sync_q;
        err_d     = 1'b0;
        snap_load = 1'b0;
        is_zero   = (p_index == '0);
        accept    = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) sum[c] = '0;
        if (p_write) begin
            accept = sync_q ? is_zero : (p_index == idx_q);
            // A mismatching index-0 write restarts the frame instead of being lost.
            if (!sync_q && !accept) err_d = 1'b1;
            if (accept || is_zero) begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    sum[c]   = sat_add(is_zero ? '0 : acc_q[c], p_term[c]);
                    acc_d[c] = sum[c];
                end
                sync_d = 1'b0;
                idx_d  = p_index + IWIDTH'(1);
                if (p_index == IWIDTH'(FEAT_DIM - 1)) begin
                    idx_d = '0;
                    for (int c = 0; c < NUM_CLASSES; c++) acc_d[c] = '0;
                    if (state_q != StIdle) err_d = 1'b1;  // overrun: drop this frame
                    else                   snap_load = 1'b1;
                end
            end else begin
                for (int c = 0; c < NUM_CLASSES; c++) acc_d[c] = '0;
                idx_d  = '0;
                sync_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
            idx_q  <= '0;
            sync_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            sync_q <= sync_d;
            err_q  <= err_d;
        end
    end

    // Scan FSM: state register / next state / outputs.
    logic [CIdxW-1:0] scan_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (snap_load) state_d = StScan;
            StScan:  if (scan_q == CIdxW'(NUM_CLASSES - 1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    logic [AWIDTH-1:0] best_dist_q;
    logic [CWIDTH-1:0] best_cls_q;
    logic              dv_q, reject_q;
    logic [CWIDTH-1:0] result_q;
    logic [AWIDTH-1:0] result_dist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CLASSES; c++) snap_q[c] <= '0;
            scan_q        <= '0;
            best_dist_q   <= '0;
            best_cls_q    <= '0;
            dv_q          <= 1'b0;
            reject_q      <= 1'b0;
            result_q      <= '0;
            result_dist_q <= '0;
        end else begin
            dv_q <= 1'b0;
            if (snap_load) begin
                snap_q <= sum;
                scan_q <= '0;
            end
            if (state_q == StScan) begin
                // Strict less-than keeps the lowest index on ties.
                if ((scan_q == '0) || (snap_q[scan_q] < best_dist_q)) begin
                    best_dist_q <= snap_q[scan_q];
                    best_cls_q  <= CWIDTH'(scan_q);
                end
                scan_q <= scan_q + CIdxW'(1);
            end
            if (state_q == StDone) begin
                result_q      <= best_cls_q;
                result_dist_q <= best_dist_q;
                reject_q      <= (best_dist_q > threshold);
                dv_q          <= 1'b1;
            end
        end
    end

    assign result_dv   = dv_q;
    assign result      = result_q;
    assign result_dist = result_dist_q;
    assign reject      = reject_q;
    assign frame_err   = err_q;

endmodule

// File: doc/feature_template_classifier.md
Name: feature_template_classifier

Overview:
- Parametrised successor to the fixed 2-bit mean-compare recogniser.
- Consumes the indexed MFCC feature stream from the MFCC front end and accumulates, per frame, the L1 distance to NUM_CLASSES stored template vectors.
- Reports the nearest class, its distance and a reject flag when the best distance exceeds a runtime threshold.
- Templates are loaded at runtime through a write port; the block sits between MFCC and the word-level control logic.

Parameters:
BWIDTH, 32, feature/template sample width (signed)
FEAT_DIM, 12, elements per feature vector
NUM_CLASSES, 5, number of templates/classes
CWIDTH, 3, class index width (>= clog2(NUM_CLASSES))
IWIDTH, 5, feature index width (>= clog2(FEAT_DIM))
AWIDTH, 40, distance accumulator width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
x_i  in  BWIDTH  signed feature element
x_index  in  IWIDTH  element index of x_i
write  in  1  x_i/x_index valid strobe
tmpl_we  in  1  template write strobe
tmpl_class  in  CWIDTH  template class to write
tmpl_index  in  IWIDTH  template element to write
tmpl_data  in  BWIDTH  signed template value
threshold  in  AWIDTH  reject threshold (unsigned)
busy  out  1  argmin scan in progress
result_dv  out  1  one-cycle result strobe
result  out  CWIDTH  winning class
result_dist  out  AWIDTH  winning distance
reject  out  1  result_dist > threshold (qualified by result_dv)
frame_err  out  1  one-cycle pulse on index sequencing error or overrun

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; accumulators 0; expected index 0; FSM to IDLE/SYNC. Template storage is NOT cleared by reset.
- Template write: on tmpl_we, tmpl[tmpl_class][tmpl_index] <= tmpl_data. Out-of-range class/index is ignored. A write during a frame takes effect for later elements.
- Accumulate on write, all classes in parallel:
  - acc[c] += |x_i - tmpl[c][x_index]|, computed at BWIDTH+1 bits.
  - Accumulators saturate at all-ones and never wrap.
- Sequencing: an internal expected-index counter must equal x_index.
  - On mismatch: pulse frame_err, clear accumulators, enter SYNC.
  - SYNC accepts a write only when x_index==0, which restarts the frame. The mismatching write itself is used if its x_index==0.
- Frame end (write with x_index==FEAT_DIM-1), edge E0:
  - Copy acc[] to the snapshot bank.
  - Clear accumulators and the expected index; the next frame may start at E0+1.
  - Enter SCAN; busy=1.
- SCAN: edges E1..E_NUM_CLASSES compare snap[k], k=0..NUM_CLASSES-1, one class per edge.
  - A strict less-than comparison replaces the best, so ties resolve to the lowest class index.
- DONE edge E_(NUM_CLASSES+1):
  - Register result and result_dist; reject = (result_dist > threshold), with threshold sampled at this edge.
  - result_dv=1 for exactly one cycle; busy=0. Return to IDLE.
- Latency: result_dv rises NUM_CLASSES+1 edges after the last element is sampled.
- result, result_dist and reject hold until the next result_dv.
- Overrun: a frame end during SCAN pulses frame_err and drops the new frame; the current scan completes normally.
- Simultaneous tmpl_we and write to the same element: the write uses the old template value.
- Reset mid-scan: the scan aborts, no result_dv, outputs return to 0.
- Invalid index (x_index >= FEAT_DIM): treated as a mismatch.

Optional Feature:
- FEAT_CLASSIFIER_SQDIST_EN defined: distance term is (x_i - tmpl)^2.
  - The difference is first saturated to signed 16 bits; the square is 32-bit unsigned and accumulation saturates as above.
  - Adds one pipeline stage, so latency becomes NUM_CLASSES+2 edges.
- Undefined: L1 absolute difference with the latency above.

Test Plan:
- Templates class c = 100*c for all 12 elements, threshold=5000, frame all 210 -> result=2, result_dist=120, reject=0, result_dv 6 edges after the last write.
- Same templates, frame all 150 -> c1 and c2 both 600 -> result=1 (tie to lower index), result_dist=600.
- Frame all 210, threshold=100 -> result=2, result_dist=120, reject=1.
- Indices 0..5 then 7 -> frame_err pulse, no result_dv; next clean 0..11 frame of 210 -> result=2, dist=120.
- Two back-to-back frames (210 then 390) with no gap -> two result_dv pulses, results 2 then 4, dist 120 then 120, frame_err=0.
- Assert reset during SCAN -> no result_dv, all outputs 0. Templates retained: the next frame of 210 -> result=2. With FEAT_CLASSIFIER_SQDIST_EN, frame 210 -> result_dist=1200.
